// File: rtl/sub_share_arbiter_if.sv
// Request/result bundle between NREQ requesters and the shared subtractor.
// Latency: none (wires only).
// Backpressure: none; requesters hold req and operands until their gnt bit pulses.
//
// Signals:
//   req    requester -> arbiter  one request bit per requester
//   a_bus  requester -> arbiter  minuend lanes, lane i = [i*DATAWIDTH +: DATAWIDTH]
//   b_bus  requester -> arbiter  subtrahend lanes, same packing
//   gnt    arbiter -> requester  one-hot grant pulse
//   diff   arbiter -> requester  a - b of the granted requester
//   borrow arbiter -> requester  1 when a < b (unsigned)
//   valid  arbiter -> requester  one-cycle pulse qualifying diff/borrow/id
//   id     arbiter -> requester  owner of the current result
interface sub_share_arbiter_if #(
    parameter int NREQ      = 4,
    parameter int DATAWIDTH = 8,
    parameter int IDW       = 2
);
    logic [NREQ-1:0]           req;
    logic [NREQ*DATAWIDTH-1:0] a_bus;
    logic [NREQ*DATAWIDTH-1:0] b_bus;
    logic [NREQ-1:0]           gnt;
    logic [DATAWIDTH-1:0]      diff;
    logic                      borrow;
    logic                      valid;
    logic [IDW-1:0]            id;

    // Requester side.
    modport master (
        output req, a_bus, b_bus,
        input  gnt, diff, borrow, valid, id
    );

    // Arbiter side.
    modport slave (
        input  req, a_bus, b_bus,
        output gnt, diff, borrow, valid, id
    );
endinterface

// File: rtl/sub_share_arbiter.sv
// Round-robin arbiter time-sharing one unsigned subtractor among NREQ requesters.
// Latency: req sampled at edge t -> gnt during t+1 -> valid/diff/borrow/id during t+2.
// Backpressure: none; one operation per two cycles, losers keep req asserted and wait.
//
// Ports:
//   Clk  rising-edge clock
//   Rst  asynchronous active-high reset
//   bus  slave side of sub_share_arbiter_if (req/a_bus/b_bus in, gnt/diff/borrow/valid/id out)
// The interface instance must be built with the same NREQ/DATAWIDTH/IDW as this module.
module sub_share_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATAWIDTH = 8,
    parameter int IDW       = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    sub_share_arbiter_if.slave    bus
);

    typedef enum logic {
        ARB   = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state_q;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       wid_q;
    logic [DATAWIDTH-1:0] opa_q;
    logic [DATAWIDTH-1:0] opb_q;
    logic [NREQ-1:0]      gnt_q;
    logic [DATAWIDTH-1:0] diff_q;
    logic                 borrow_q;
    logic                 valid_q;
    logic [IDW-1:0]       id_q;

    // Arbitration results for the current cycle.
    logic                 any_req;
    logic [IDW-1:0]       win_d;
    logic [IDW-1:0]       ptr_d;
    logic [NREQ-1:0]      gnt_d;
    logic [DATAWIDTH-1:0] opa_d;
    logic [DATAWIDTH-1:0] opb_d;

    // Round-robin pick without a rotator: the lowest set bit at or above ptr
    // wins; if there is none, the search wraps and the lowest set bit overall
    // wins. Loops run downward so the last assignment is the lowest index.
    logic           hi_found;
    logic [IDW-1:0] hi_idx;
    logic [IDW-1:0] lo_idx;

    always_comb begin
        any_req  = |bus.req;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                lo_idx = IDW'(i);
            end
            if (bus.req[i] && (i >= int'(ptr_q))) begin
                hi_found = 1'b1;
                hi_idx   = IDW'(i);
            end
        end
        win_d = hi_found ? hi_idx : lo_idx;
    end

    // Pointer moves just past the winner, wrapping NREQ-1 -> 0 so it never
    // holds an index outside the requester range.
    always_comb begin
        if (win_d == IDW'(NREQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = win_d + IDW'(1);
        end
    end

    // One-hot grant and operand lane mux for the winner.
    always_comb begin
        gnt_d = '0;
        opa_d = '0;
        opb_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_d == IDW'(i)) begin
                gnt_d[i] = 1'b1;
                opa_d    = bus.a_bus[i*DATAWIDTH +: DATAWIDTH];
                opb_d    = bus.b_bus[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // Two-state controller with registered outputs. Operands are captured at
    // the arbitration edge so lane changes during the gnt cycle are harmless.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= ARB;
            ptr_q    <= '0;
            wid_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            gnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            valid_q  <= 1'b0;
            id_q     <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    valid_q <= 1'b0;
                    if (any_req) begin
                        gnt_q   <= gnt_d;
                        opa_q   <= opa_d;
                        opb_q   <= opb_d;
                        wid_q   <= win_d;
                        ptr_q   <= ptr_d;
                        state_q <= GRANT;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                GRANT: begin
                    // req is deliberately ignored here; a requester still
                    // asserting next cycle competes as a fresh request.
                    diff_q   <= opa_q - opb_q;
                    borrow_q <= (opa_q < opb_q);
                    id_q     <= wid_q;
                    valid_q  <= 1'b1;
                    gnt_q    <= '0;
                    state_q  <= ARB;
                end
                default: begin
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                    state_q <= ARB;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.valid  = valid_q;
    assign bus.id     = id_q;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Bench for sub_share_arbiter: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based reference model.
module tb_sub_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IDW  = 2;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    sub_share_arbiter_if #(.NREQ(NREQ), .DATAWIDTH(DW), .IDW(IDW)) bus ();

    sub_share_arbiter #(.NREQ(NREQ), .DATAWIDTH(DW), .IDW(IDW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    // Requester-side stimulus, packed onto the interface.
    logic [NREQ-1:0] req_l;
    logic [DW-1:0]   a_l [NREQ];
    logic [DW-1:0]   b_l [NREQ];

    always_comb begin
        bus.req = req_l;
        for (int i = 0; i < NREQ; i++) begin
            bus.a_bus[i*DW +: DW] = a_l[i];
            bus.b_bus[i*DW +: DW] = b_l[i];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted request becomes a result due one cycle
    // after its grant; a grant is impossible in the cycle right after a grant.
    typedef struct {
        int            due;
        logic [DW-1:0] d;
        logic          br;
        int            id;
    } res_t;

    res_t            rq[$];
    int              cyc;
    int              last_gnt;
    int              m_ptr;
    logic [NREQ-1:0] e_gnt;
    logic            e_valid;
    logic [DW-1:0]   h_diff;
    logic            h_borrow;
    int              h_id;

    function automatic void model_reset();
        rq.delete();
        m_ptr    = 0;
        last_gnt = -100;
        e_gnt    = '0;
        e_valid  = 1'b0;
        h_diff   = '0;
        h_borrow = 1'b0;
        h_id     = 0;
    endfunction

    function automatic void model_edge();
        int   w;
        res_t r;
        cyc++;
        e_gnt   = '0;
        e_valid = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            h_diff   = rq[0].d;
            h_borrow = rq[0].br;
            h_id     = rq[0].id;
            e_valid  = 1'b1;
            void'(rq.pop_front());
        end
        if (cyc != last_gnt + 1 && req_l != '0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (w < 0 && req_l[j]) w = j;
            end
            e_gnt[w] = 1'b1;
            r.due    = cyc + 1;
            r.d      = a_l[w] - b_l[w];
            r.br     = (int'(a_l[w]) < int'(b_l[w]));
            r.id     = w;
            rq.push_back(r);
            last_gnt = cyc;
            m_ptr    = (w + 1) % NREQ;
        end
    endfunction

    task automatic compare_outputs();
        chk("gnt",    32'(bus.gnt),    32'(e_gnt));
        chk("valid",  32'(bus.valid),  32'(e_valid));
        chk("diff",   32'(bus.diff),   32'(h_diff));
        chk("borrow", 32'(bus.borrow), 32'(h_borrow));
        chk("id",     32'(bus.id),     32'(h_id));
    endtask

    // One clock: model advances at the edge, outputs checked at the falling edge.
    task automatic step();
        @(posedge Clk);
        if (Rst) model_reset();
        else     model_edge();
        @(negedge Clk);
        compare_outputs();
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge.
    task automatic do_reset();
        Rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        step();
        Rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        req_l = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_l[i] = '0;
            b_l[i] = '0;
        end
        cyc = 0;
        model_reset();

        // Reset state.
        @(negedge Clk);
        chk("rst_gnt",   32'(bus.gnt),   32'h0);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_diff",  32'(bus.diff),  32'h0);
        Rst = 1'b0;

        // Single request; lane changed during gnt cycle must not matter.
        req_l = 4'b0001; a_l[0] = 8'd20; b_l[0] = 8'd7;
        step();
        chk("single_gnt", 32'(bus.gnt), 32'h1);
        a_l[0] = 8'd99; req_l = '0;
        step();
        chk("single_valid",  32'(bus.valid),  32'h1);
        chk("single_diff",   32'(bus.diff),   32'd13);
        chk("single_borrow", 32'(bus.borrow), 32'h0);
        chk("single_id",     32'(bus.id),     32'h0);
        step();
        chk("single_valid_off", 32'(bus.valid), 32'h0);
        chk("single_hold_diff", 32'(bus.diff),  32'd13);

        // Round-robin with all requesters held high.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_l[i] = DW'(40 + 10 * i);
            b_l[i] = DW'(3 * i + 1);
        end
        req_l = 4'b1111;
        for (int n = 0; n < 10; n++) begin
            step();
            if (n % 2 == 0) begin
                chk("rr_gnt", 32'(bus.gnt), 32'(1) << ((n / 2) % 4));
            end else begin
                chk("rr_id",   32'(bus.id),   32'((n / 2) % 4));
                chk("rr_diff", 32'(bus.diff), 32'(39 + 7 * ((n / 2) % 4)));
            end
        end
        req_l = '0;

        // Pointer wrap: after lane 2 wins, 0101 must go to lane 0, then lane 2.
        do_reset();
        req_l = 4'b0100;
        step();
        chk("wrap_gnt2", 32'(bus.gnt), 32'h4);
        req_l = 4'b0101;
        step();
        chk("wrap_id2", 32'(bus.id), 32'h2);
        step();
        chk("wrap_gnt0", 32'(bus.gnt), 32'h1);
        step();
        step();
        chk("wrap_gnt2b", 32'(bus.gnt), 32'h4);
        req_l = '0;
        step();

        // Borrow and equal-operand corners.
        req_l = 4'b0010; a_l[1] = 8'd3; b_l[1] = 8'd5;
        step();
        req_l = '0;
        step();
        chk("borrow_diff", 32'(bus.diff),   32'hFE);
        chk("borrow_flag", 32'(bus.borrow), 32'h1);
        chk("borrow_id",   32'(bus.id),     32'h1);
        req_l = 4'b0010; a_l[1] = 8'hFF; b_l[1] = 8'hFF;
        step();
        req_l = '0;
        step();
        chk("equal_diff", 32'(bus.diff),   32'h0);
        chk("equal_flag", 32'(bus.borrow), 32'h0);

        // Reset during GRANT: outputs clear immediately, captured op discarded.
        req_l = 4'b0010; a_l[1] = 8'd9; b_l[1] = 8'd4;
        step();
        req_l = '0;
        step();
        chk("pre_rst_diff", 32'(bus.diff), 32'd5);
        req_l = 4'b0100; a_l[2] = 8'd50; b_l[2] = 8'd8;
        step();
        chk("pre_rst_gnt", 32'(bus.gnt), 32'h4);
        req_l = '0;
        #2;
        Rst = 1'b1;
        #1;
        chk("midrst_gnt",    32'(bus.gnt),    32'h0);
        chk("midrst_valid",  32'(bus.valid),  32'h0);
        chk("midrst_diff",   32'(bus.diff),   32'h0);
        chk("midrst_borrow", 32'(bus.borrow), 32'h0);
        chk("midrst_id",     32'(bus.id),     32'h0);
        model_reset();
        step();
        Rst = 1'b0;
        step();
        chk("post_rst_novalid", 32'(bus.valid), 32'h0);
        step();
        req_l = 4'b1010;
        step();
        chk("post_rst_gnt", 32'(bus.gnt), 32'h2);
        req_l = '0;
        step();

        // Random traffic against the model, with occasional async resets.
        for (int n = 0; n < 400; n++) begin
            req_l = ($urandom_range(0, 4) == 0) ? '0 : NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 7))
                    0:       a_l[i] = 8'h00;
                    1:       a_l[i] = 8'hFF;
                    default: a_l[i] = DW'($urandom);
                endcase
                case ($urandom_range(0, 7))
                    0:       b_l[i] = 8'h00;
                    1:       b_l[i] = 8'hFF;
                    2:       b_l[i] = a_l[i];
                    default: b_l[i] = DW'($urandom);
                endcase
            end
            if ($urandom_range(0, 59) == 0) begin
                #2;
                do_reset();
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
